// File: rtl/serial_deserializer_pkg.sv
// Shared types for the serial deserializer: FSM state encoding and counter sizing.
package serial_deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_out_reg.sv
// One-word valid/ready holding register for assembled words, with a sticky
// overflow flag raised when a completed word cannot be accepted.
module deser_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_perr,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_perr,
  output logic             overflow
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ovf_q, ovf_d;
  logic             load_ok;

  // A pop in the same cycle frees the slot for the incoming word.
  assign load_ok = load && (!valid_q || out_ready);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovf_d   = ovf_q;
    if (load_ok) begin
      data_d  = load_data;
      perr_d  = load_perr;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (load && !load_ok) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_perr  = perr_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out frame deserializer with valid/ready output.
// Optional even-parity bit per frame enabled by SERIAL_DESERIALIZER_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for a frame_start bit
// SHIFT | collecting data bits, cnt = bits received so far
// PAR   | all data bits in, waiting for the parity bit
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr,
  output logic             overflow
);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] start_vec, push_vec;
  logic             deliver;
  logic [WIDTH-1:0] word;
  logic             word_perr;

  // The first bit enters at the far end so that after WIDTH bits it sits at
  // the MSB (MSB_FIRST) or the LSB (!MSB_FIRST).
  always_comb begin
    if (MSB_FIRST) begin
      start_vec = {{(WIDTH-1){1'b0}}, bit_in};
      push_vec  = {shift_q[WIDTH-2:0], bit_in};
    end else begin
      start_vec = {bit_in, {(WIDTH-1){1'b0}}};
      push_vec  = {bit_in, shift_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (bit_en) begin
      if (frame_start) begin
        state_d = SHIFT;
        cnt_d   = CW'(1);
        shift_d = start_vec;
      end else begin
        case (state_q)
          SHIFT: begin
            shift_d = push_vec;
            if (cnt_q == LAST_CNT) begin
              if (PAR_EN) begin
                state_d = PAR;
                cnt_d   = FULL_CNT;
              end else begin
                state_d = IDLE;
                cnt_d   = '0;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          PAR: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    deliver   = 1'b0;
    word      = push_vec;
    word_perr = 1'b0;
    if (bit_en && !frame_start) begin
      if (state_q == SHIFT && cnt_q == LAST_CNT && !PAR_EN) begin
        deliver = 1'b1;
      end
      if (state_q == PAR) begin
        deliver   = 1'b1;
        word      = shift_q;
        word_perr = PAR_EN & ((^shift_q) ^ bit_in);
      end
    end
  end

  deser_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (deliver),
    .load_data(word),
    .load_perr(word_perr),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_perr (out_perr),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: MSB-first and LSB-first instances on shared
// inputs, directed frame table, corner sequences and a random run vs a model.
module tb_serial_deserializer;

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int W    = 8;
  localparam int FLEN = W + (PAR_EN ? 1 : 0);

  logic clk = 1'b0;
  logic rst_n, bit_in, bit_en, frame_start, out_ready;
  logic [W-1:0] d_m, d_l;
  logic v_m, v_l, p_m, p_l, o_m, o_l;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_en(bit_en),
    .frame_start(frame_start), .out_data(d_m), .out_valid(v_m),
    .out_ready(out_ready), .out_perr(p_m), .overflow(o_m));

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_en(bit_en),
    .frame_start(frame_start), .out_data(d_l), .out_valid(v_l),
    .out_ready(out_ready), .out_perr(p_l), .overflow(o_l));

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the current frame in arrival order.
  bit         fr[$];
  bit         in_frame = 1'b0;
  logic [W-1:0] m_dm = '0, m_dl = '0;
  bit         m_valid = 1'b0, m_perr = 1'b0, m_ovf = 1'b0;

  typedef struct {
    logic [7:0] send;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit dlv;
    bit px;
    logic [W-1:0] wm, wl;
    dlv = 1'b0;
    px  = 1'b0;
    wm  = '0;
    wl  = '0;
    if (!rst_n) begin
      fr.delete();
      in_frame = 1'b0;
      m_valid = 1'b0; m_dm = '0; m_dl = '0; m_perr = 1'b0; m_ovf = 1'b0;
      return;
    end
    if (bit_en) begin
      if (frame_start) begin
        fr.delete();
        fr.push_back(bit_in);
        in_frame = 1'b1;
      end else if (in_frame) begin
        fr.push_back(bit_in);
      end
      if (in_frame && fr.size() == FLEN) begin
        dlv = 1'b1;
        for (int i = 0; i < FLEN; i++) px ^= fr[i];
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = fr[i];
          wl[i]     = fr[i];
        end
        fr.delete();
        in_frame = 1'b0;
      end
    end
    if (dlv) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1; m_dm = wm; m_dl = wl; m_perr = PAR_EN ? px : 1'b0;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model_valid_m", v_m, m_valid);
    check("model_valid_l", v_l, m_valid);
    check("model_data_m", d_m, m_dm);
    check("model_data_l", d_l, m_dl);
    check("model_perr_m", p_m, m_perr);
    check("model_perr_l", p_l, m_perr);
    check("model_ovf_m", o_m, m_ovf);
    check("model_ovf_l", o_l, m_ovf);
  endtask

  task automatic send_bits(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      bit_en = 1'b1;
      frame_start = (i == 0);
      bit_in = s[7-i];
      step();
    end
    bit_en = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] s, input logic pbit);
    send_bits(s, W);
    if (PAR_EN) begin
      bit_en = 1'b1;
      bit_in = pbit;
      step();
      bit_en = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{8'h80, 8'h80, 8'h01};
    tbl[2] = '{8'h3C, 8'h3C, 8'h3C};
    tbl[3] = '{8'h12, 8'h12, 8'h48};
    tbl[4] = '{8'hE0, 8'hE0, 8'h07};
    tbl[5] = '{8'h5A, 8'h5A, 8'h5A};

    rst_n = 1'b0; bit_in = 1'b0; bit_en = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("rst_valid", v_m, 1'b0);
    check("rst_data", d_m, 8'h00);
    check("rst_perr", p_m, 1'b0);
    check("rst_ovf", o_m, 1'b0);
    rst_n = 1'b1;
    step();

    // Back-to-back frames with out_ready held high.
    for (int k = 0; k < 6; k++) begin
      send_frame(tbl[k].send, ^tbl[k].send);
      check("tbl_valid", v_m, 1'b1);
      check("tbl_data_msb", d_m, tbl[k].exp_m);
      check("tbl_data_lsb", d_l, tbl[k].exp_l);
      check("tbl_perr", p_m, 1'b0);
      check("tbl_ovf", o_m, 1'b0);
    end
    step();
    check("pop_clears_valid", v_m, 1'b0);

    // Second word dropped while the first is held.
    out_ready = 1'b0;
    send_frame(8'h3C, ^8'h3C);
    send_frame(8'hC3, ^8'hC3);
    check("ovf_hold_data", d_m, 8'h3C);
    check("ovf_hold_valid", v_m, 1'b1);
    check("ovf_set", o_m, 1'b1);
    out_ready = 1'b1;
    step();
    check("ovf_pop_valid", v_m, 1'b0);
    check("ovf_sticky", o_m, 1'b1);

    // Abort after 5 bits, then a full frame.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    send_bits(8'hFF, 5);
    check("abort_no_valid", v_m, 1'b0);
    send_frame(8'hFF, ^8'hFF);
    check("abort_data", d_m, 8'hFF);
    check("abort_valid", v_m, 1'b1);
    check("abort_ovf", o_m, 1'b0);
    step();

    // Reset mid-frame while a word is held.
    out_ready = 1'b0;
    send_frame(8'h5A, ^8'h5A);
    send_bits(8'hF0, 3);
    check("pre_rst_valid", v_m, 1'b1);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", v_m, 1'b0);
    check("mid_rst_data", d_m, 8'h00);
    check("mid_rst_data_l", d_l, 8'h00);
    check("mid_rst_ovf", o_m, 1'b0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_frame(8'h5A, ^8'h5A);
    check("post_rst_data", d_m, 8'h5A);
    check("post_rst_valid", v_m, 1'b1);
    step();

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    send_frame(8'h07, 1'b1);
    check("par_ok_data", d_m, 8'h07);
    check("par_ok_perr", p_m, 1'b0);
    step();
    send_frame(8'h07, 1'b0);
    check("par_bad_data", d_m, 8'h07);
    check("par_bad_valid", v_m, 1'b1);
    check("par_bad_perr", p_m, 1'b1);
    step();
`endif

    // Random sparse traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      bit_en      = ($urandom_range(0, 9) < 7);
      frame_start = ($urandom_range(0, 15) == 0);
      bit_in      = $urandom_range(0, 1);
      out_ready   = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-in/parallel-out deserializer that consumes the registered single-bit stream produced by the team's D flip-flop stage and assembles framed words. It sits directly downstream of the flop, qualifies each incoming bit with an enable strobe, and presents completed words on a valid/ready output port with a one-word holding register.

## Interface
Parameters:
- WIDTH, 8, data bits per frame (2..32)
- MSB_FIRST, 1, 1: first received bit lands in out_data[WIDTH-1]; 0: first bit lands in out_data[0]

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- bit_in  input  1  serial data bit from the upstream flop Q
- bit_en  input  1  bit_in is valid this cycle
- frame_start  input  1  qualified by bit_en; marks bit_in as the first bit of a frame
- out_data  output  WIDTH  assembled word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  downstream accepts the word when out_valid && out_ready
- out_perr  output  1  parity-error sideband travelling with out_data
- overflow  output  1  sticky: a completed word was dropped

## Operation
- FSM states: IDLE, SHIFT, PAR. PAR exists only with the parity feature.
- IDLE: bit_en && frame_start: capture bit_in as bit 1, cnt=1, go to SHIFT. bit_en without frame_start: bit ignored.
- SHIFT: each bit_en shifts bit_in in and increments cnt. The WIDTH-th bit completes the frame: go to PAR if parity is enabled, else deliver and return to IDLE.
- frame_start && bit_en in SHIFT or PAR: partial frame discarded, the bit becomes bit 1 of a new frame, cnt=1. No overflow is raised.
- Delivery: the word loads into the holding register if out_valid==0, or if out_valid && out_ready in the same cycle. Otherwise the word is dropped, the holding register is unchanged, and overflow is set.
- Handshake: out_valid, out_data and out_perr are stable while out_valid && !out_ready. out_valid clears after a cycle with out_ready=1 and no new delivery.
- Simultaneous pop and delivery: out_valid stays 1 and the new word replaces the old one.
- cnt width is $clog2(WIDTH+1). It never exceeds WIDTH and never wraps.
- overflow is cleared only by reset.

## Timing
- All outputs are registered. Reset values: out_data=0, out_valid=0, out_perr=0, overflow=0. FSM is IDLE, cnt=0.
- Latency: final frame bit (data bit, or parity bit when enabled) accepted at edge N; out_valid=1 and out_data valid from edge N onward, so visible in cycle N+1.
- bit_en may be sparse. Gaps of any length between bits are allowed; state holds while bit_en=0.
- rst_n low mid-frame or while out_valid=1: the partial frame and the held word are lost, and all outputs return to reset values on that edge.
- Throughput: one bit per cycle sustained. A back-to-back frame start on the cycle after the last bit is accepted.

## Configuration
- Macro: SERIAL_DESERIALIZER_PARITY_EN.
- Defined: each frame carries one extra bit after the data bits (PAR state). Parity is even: XOR of WIDTH data bits plus the parity bit must equal 0. out_perr=1 is registered with the word on a mismatch. The word is delivered regardless of the parity result.
- Undefined: frame is WIDTH bits, there is no PAR state, and out_perr is tied 0.

## Structure
- Package serial_deserializer_pkg: FSM state enum (IDLE, SHIFT, PAR) and the function computing counter width from WIDTH.
- Sub-module deser_out_reg: the holding register with valid/ready, load/pop arbitration and the overflow flag. The FSM and shift register stay in the top module.

## Test plan
- WIDTH=8, MSB_FIRST=1: frame_start plus bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_ready=1 -> out_valid for one cycle, out_data=8'hA5, overflow=0.
- MSB_FIRST=0, same bit sequence -> out_data=8'hA5 bit-reversed = 8'hA5 (palindrome). Repeat with bits 1,0,0,0,0,0,0,0 -> out_data=8'h01.
- Two back-to-back frames 8'h3C then 8'hC3 with out_ready=0 -> out_data held at 8'h3C, overflow=1 after the second frame. Then out_ready=1 for one cycle -> out_valid=0.
- frame_start reasserted after 5 bits, followed by a full 8-bit frame 8'hFF -> single delivery 8'hFF, no overflow.
- rst_n=0 for one cycle mid-frame with out_valid=1 -> all outputs 0 next cycle. The next full frame 8'h5A is delivered correctly.
- With SERIAL_DESERIALIZER_PARITY_EN: frame 8'h07 with parity bit 1 -> out_perr=0. Same frame with parity bit 0 -> out_perr=1, data 8'h07 still delivered.
